// File: rtl/countdown_controller.sv
// countdown_controller
//   Egg-timer controller: key edge detection, SEC/MIN set-up, a prescaled
//   countdown, pause/resume and a timed alarm. When the alarm ends, the
//   time that was started is reloaded.
//
// Ports
//   CLK    in   1      system clock, all logic on the rising edge
//   RST_N  in   1      synchronous active-low reset
//   KEY    in   3      debounced active-high keys:
//                      [0] clear, [1] advance/start/pause, [2] increment
//   STATE  out  3      current FSM state (RESET..SET_MIN..READY keep legacy codes)
//   SEC    out  6      seconds, 0..59
//   MIN    out  MIN_W  minutes, 0..MIN_MAX
//   TICK   out  1      one-cycle pulse on each countdown decrement
//   ALARM  out  1      high while in the ALARM state
module countdown_controller #(
    parameter int TICK_DIV  = 50000000,
    parameter int MIN_W     = 7,
    parameter int MIN_MAX   = 99,
    parameter int ALARM_CYC = 250000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [2:0]       KEY,
    output logic [2:0]       STATE,
    output logic [5:0]       SEC,
    output logic [MIN_W-1:0] MIN,
    output logic             TICK,
    output logic             ALARM
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ALARM_CYC + 1);

    localparam logic [PW-1:0]    PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0]    ALARM_TOP = AW'(ALARM_CYC - 1);
    localparam logic [MIN_W-1:0] MIN_TOP   = MIN_W'(MIN_MAX);
    localparam logic [5:0]       SEC_TOP   = 6'd59;

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_SET_SEC = 3'd1,
        S_SET_MIN = 3'd2,
        S_READY   = 3'd3,
        S_RUN     = 3'd4,
        S_PAUSE   = 3'd5,
        S_ALARM   = 3'd6
    } state_t;

    state_t           r_state;
    logic [2:0]       r_key_q;
    logic [5:0]       r_sec;
    logic [MIN_W-1:0] r_min;
    logic [PW-1:0]    r_presc;
    logic [AW-1:0]    r_acnt;
    logic [5:0]       r_psec;
    logic [MIN_W-1:0] r_pmin;
    logic             r_tick;
    logic             r_alarm;

    state_t           w_state_nxt;
    logic [5:0]       w_sec_nxt;
    logic [MIN_W-1:0] w_min_nxt;
    logic [PW-1:0]    w_presc_nxt;
    logic [AW-1:0]    w_acnt_nxt;
    logic [5:0]       w_psec_nxt;
    logic [MIN_W-1:0] w_pmin_nxt;
    logic             w_tick_evt;
    logic             w_tick_nxt;
    logic             w_alarm_nxt;

    logic [2:0]       w_press;
    logic             w_clear;
    logic [5:0]       w_dec_sec;
    logic [MIN_W-1:0] w_dec_min;
    logic             w_dec_zero;

    assign w_press = KEY & ~r_key_q;
    // Clear applies in every defined state except RESET; code 7 just falls back to RESET.
    assign w_clear = w_press[0] && (r_state != S_RESET) && (r_state <= S_ALARM);

    // One-second decrement; 00:00 can only follow from 00:01.
    always_comb begin
        w_dec_sec  = r_sec;
        w_dec_min  = r_min;
        w_dec_zero = 1'b0;
        if (r_sec != 6'd0) begin
            w_dec_sec  = r_sec - 6'd1;
            w_dec_zero = (r_sec == 6'd1) && (r_min == '0);
        end else begin
            w_dec_sec = SEC_TOP;
            w_dec_min = r_min - MIN_W'(1);
        end
    end

    // State register and datapath registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_RESET;
            r_key_q <= '0;
            r_sec   <= '0;
            r_min   <= '0;
            r_presc <= '0;
            r_acnt  <= '0;
            r_psec  <= '0;
            r_pmin  <= '0;
            r_tick  <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key_q <= KEY;
            r_sec   <= w_sec_nxt;
            r_min   <= w_min_nxt;
            r_presc <= w_presc_nxt;
            r_acnt  <= w_acnt_nxt;
            r_psec  <= w_psec_nxt;
            r_pmin  <= w_pmin_nxt;
            r_tick  <= w_tick_nxt;
            r_alarm <= w_alarm_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_presc_nxt = r_presc;
        w_acnt_nxt  = r_acnt;
        w_psec_nxt  = r_psec;
        w_pmin_nxt  = r_pmin;
        w_tick_evt  = 1'b0;

        if (w_clear) begin
            w_state_nxt = S_SET_SEC;
            w_sec_nxt   = '0;
            w_min_nxt   = '0;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                S_RESET: w_state_nxt = S_SET_SEC;

                S_SET_SEC: begin
                    if (w_press[1])
                        w_state_nxt = S_SET_MIN;
                    else if (w_press[2])
                        w_sec_nxt = (r_sec == SEC_TOP) ? '0 : r_sec + 6'd1;
                end

                S_SET_MIN: begin
                    if (w_press[1])
                        w_state_nxt = S_READY;
                    else if (w_press[2])
                        w_min_nxt = (r_min == MIN_TOP) ? '0 : r_min + MIN_W'(1);
                end

                S_READY: begin
                    if (w_press[1] && ((r_sec != '0) || (r_min != '0))) begin
                        w_state_nxt = S_RUN;
                        w_psec_nxt  = r_sec;
                        w_pmin_nxt  = r_min;
                        w_presc_nxt = '0;
                    end
                end

                // The prescaler counts on the pause edge as well; it only
                // freezes while in PAUSE. A tick reaching 00:00 beats a pause.
                S_RUN: begin
                    if (r_presc == PRESC_TOP) begin
                        w_presc_nxt = '0;
                        w_tick_evt  = 1'b1;
                        w_sec_nxt   = w_dec_sec;
                        w_min_nxt   = w_dec_min;
                        if (w_dec_zero) begin
                            w_state_nxt = S_ALARM;
                            w_acnt_nxt  = '0;
                        end else if (w_press[1]) begin
                            w_state_nxt = S_PAUSE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                        if (w_press[1])
                            w_state_nxt = S_PAUSE;
                    end
                end

                S_PAUSE: begin
                    if (w_press[1])
                        w_state_nxt = S_RUN;
                end

                S_ALARM: begin
                    if ((r_acnt == ALARM_TOP) || w_press[1]) begin
                        w_state_nxt = S_READY;
                        w_sec_nxt   = r_psec;
                        w_min_nxt   = r_pmin;
                    end else begin
                        w_acnt_nxt = r_acnt + AW'(1);
                    end
                end

                default: w_state_nxt = S_RESET;
            endcase
        end
    end

    // Output decode, registered alongside the state
    always_comb begin
        w_tick_nxt  = w_tick_evt;
        w_alarm_nxt = (w_state_nxt == S_ALARM);
    end

    assign STATE = r_state;
    assign SEC   = r_sec;
    assign MIN   = r_min;
    assign TICK  = r_tick;
    assign ALARM = r_alarm;

endmodule

// File: tb/tb_countdown_controller.sv
// tb_countdown_controller
//   Directed walk through the timer's behaviour followed by randomized key
//   and reset traffic. Every cycle the DUT outputs are compared with a
//   behavioural model that tracks the timer as minutes/seconds fields,
//   with countdown arithmetic on total seconds and elapsed-cycle counts.
module tb_countdown_controller;

    localparam int TICK_DIV  = 4;
    localparam int MIN_W     = 2;
    localparam int MIN_MAX   = 3;
    localparam int ALARM_CYC = 8;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [2:0]       KEY = 3'b000;
    logic [2:0]       STATE;
    logic [5:0]       SEC;
    logic [MIN_W-1:0] MIN;
    logic             TICK;
    logic             ALARM;

    always #5 CLK = ~CLK;

    countdown_controller #(
        .TICK_DIV  (TICK_DIV),
        .MIN_W     (MIN_W),
        .MIN_MAX   (MIN_MAX),
        .ALARM_CYC (ALARM_CYC)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .KEY   (KEY),
        .STATE (STATE),
        .SEC   (SEC),
        .MIN   (MIN),
        .TICK  (TICK),
        .ALARM (ALARM)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: state number, time fields, cycles elapsed in the current
    // second, cycles spent alarming, and the started time.
    int       m_state = 0;
    int       m_sec   = 0;
    int       m_min   = 0;
    int       m_phase = 0;
    int       m_acnt  = 0;
    int       m_psec  = 0;
    int       m_pmin  = 0;
    int       m_tick  = 0;
    bit [2:0] m_kprev = 3'b000;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst_n_v, input bit [2:0] k);
        bit [2:0] p;
        int       total;
        m_tick = 0;
        if (!rst_n_v) begin
            m_state = 0; m_sec = 0; m_min = 0; m_phase = 0;
            m_acnt = 0; m_psec = 0; m_pmin = 0; m_kprev = 3'b000;
            return;
        end
        p       = k & ~m_kprev;
        m_kprev = k;
        if (m_state != 0 && p[0]) begin
            m_state = 1; m_sec = 0; m_min = 0; m_phase = 0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (p[1]) m_state = 2;
                   else if (p[2]) m_sec = (m_sec + 1) % 60;
                2: if (p[1]) m_state = 3;
                   else if (p[2]) m_min = (m_min + 1) % (MIN_MAX + 1);
                3: if (p[1] && (m_min * 60 + m_sec) != 0) begin
                       m_state = 4; m_psec = m_sec; m_pmin = m_min; m_phase = 0;
                   end
                4: begin
                    m_phase++;
                    if (m_phase == TICK_DIV) begin
                        m_phase = 0;
                        m_tick  = 1;
                        total   = m_min * 60 + m_sec - 1;
                        m_min   = total / 60;
                        m_sec   = total % 60;
                        if (total == 0) begin
                            m_state = 6; m_acnt = 0;
                        end else if (p[1]) begin
                            m_state = 5;
                        end
                    end else if (p[1]) begin
                        m_state = 5;
                    end
                end
                5: if (p[1]) m_state = 4;
                6: begin
                    m_acnt++;
                    if (m_acnt == ALARM_CYC || p[1]) begin
                        m_state = 3; m_sec = m_psec; m_min = m_pmin;
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic cyc(input bit rst_n_v, input bit [2:0] k);
        @(negedge CLK);
        RST_N = rst_n_v;
        KEY   = k;
        @(posedge CLK);
        model_step(rst_n_v, k);
        #1;
        check_eq("state", int'(STATE), m_state);
        check_eq("sec",   int'(SEC),   m_sec);
        check_eq("min",   int'(MIN),   m_min);
        check_eq("tick",  int'(TICK),  m_tick);
        check_eq("alarm", int'(ALARM), (m_state == 6) ? 1 : 0);
    endtask

    task automatic step(input bit [2:0] k);
        cyc(1'b1, k);
    endtask

    task automatic tap(input int b);
        step(3'(1 << b));
        step(3'b000);
    endtask

    int exp_min[5] = '{1, 2, 3, 0, 1};
    int ticks;

    initial begin
        // Reset and release
        cyc(1'b0, 3'b000);
        cyc(1'b0, 3'b000);
        check_eq("rst_state", int'(STATE), 0);
        check_eq("rst_sec",   int'(SEC),   0);
        check_eq("rst_min",   int'(MIN),   0);
        check_eq("rst_alarm", int'(ALARM), 0);
        check_eq("rst_tick",  int'(TICK),  0);
        step(3'b000);
        check_eq("release_state", int'(STATE), 1);

        // Seconds setting: wrap, held key, coincident keys
        repeat (61) tap(2);
        check_eq("sec_wrap", int'(SEC), 1);
        repeat (10) step(3'b100);
        step(3'b000);
        check_eq("sec_held", int'(SEC), 2);
        step(3'b110);
        check_eq("prio_state", int'(STATE), 2);
        check_eq("prio_sec",   int'(SEC),   2);
        step(3'b000);

        // Minutes setting wrap, READY entry, 00:00 start ignored
        for (int i = 0; i < 5; i++) begin
            tap(2);
            check_eq("min_seq", int'(MIN), exp_min[i]);
        end
        tap(1);
        check_eq("ready_state", int'(STATE), 3);
        tap(0);
        tap(1);
        tap(1);
        tap(1);
        check_eq("zero_start", int'(STATE), 3);

        // 1:00 start, first tick borrows into minutes
        tap(0); tap(1); tap(2); tap(1);
        step(3'b010);
        check_eq("run_state", int'(STATE), 4);
        repeat (3) step(3'b000);
        check_eq("pre_tick", int'(TICK), 0);
        step(3'b000);
        check_eq("tick1", int'(TICK), 1);
        check_eq("borrow_min", int'(MIN), 0);
        check_eq("borrow_sec", int'(SEC), 59);
        step(3'b000);

        // 0:02 runs to alarm, alarm times out and reloads preset
        tap(0); tap(2); tap(2); tap(1); tap(1);
        step(3'b010);
        repeat (7) step(3'b000);
        check_eq("pre_alarm", int'(ALARM), 0);
        step(3'b000);
        check_eq("alarm_on",    int'(ALARM), 1);
        check_eq("alarm_state", int'(STATE), 6);
        repeat (7) step(3'b000);
        check_eq("alarm_hold", int'(ALARM), 1);
        step(3'b000);
        check_eq("reload_state", int'(STATE), 3);
        check_eq("reload_alarm", int'(ALARM), 0);
        check_eq("reload_sec",   int'(SEC),   2);
        check_eq("reload_min",   int'(MIN),   0);

        // 0:05 pause two cycles in, hold, resume
        tap(0);
        repeat (5) tap(2);
        tap(1); tap(1);
        step(3'b010);
        step(3'b000);
        step(3'b010);
        check_eq("pause_state", int'(STATE), 5);
        ticks = 0;
        repeat (20) begin
            step(3'b000);
            ticks += int'(TICK);
        end
        check_eq("pause_ticks", ticks, 0);
        check_eq("pause_sec",   int'(SEC), 5);
        step(3'b010);
        check_eq("resume_state", int'(STATE), 4);
        step(3'b000);
        check_eq("resume_notick", int'(TICK), 0);
        step(3'b000);
        check_eq("resume_tick", int'(TICK), 1);
        check_eq("resume_sec",  int'(SEC),  4);

        // Clear during RUN at 0:03
        repeat (3) step(3'b000);
        step(3'b000);
        check_eq("run_sec3", int'(SEC), 3);
        step(3'b001);
        check_eq("clear_state", int'(STATE), 1);
        check_eq("clear_sec",   int'(SEC),   0);
        check_eq("clear_min",   int'(MIN),   0);
        step(3'b000);

        // Advance key cuts the alarm short
        tap(2); tap(1); tap(1);
        step(3'b010);
        repeat (4) step(3'b000);
        check_eq("alarm2_on", int'(ALARM), 1);
        step(3'b000);
        step(3'b010);
        check_eq("ack_state", int'(STATE), 3);
        check_eq("ack_alarm", int'(ALARM), 0);
        check_eq("ack_sec",   int'(SEC),   1);
        step(3'b000);

        // Reset in the middle of a run
        tap(1);
        check_eq("run2_state", int'(STATE), 4);
        cyc(1'b0, 3'b000);
        check_eq("midrun_rst", int'(STATE), 0);
        cyc(1'b0, 3'b000);

        // Randomized keys with occasional resets
        repeat (4000) begin
            bit       r;
            bit [2:0] k;
            r = ($urandom_range(0, 299) != 0);
            k = {($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 39) == 0)};
            cyc(r, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
